// File: rtl/inst_encoder_loader.sv
// Instruction encoder/loader: packs field bundles into 32-bit instruction words and
// writes them to consecutive IMEM words, holding the CPU in reset until the load completes.
//
// state | meaning
// IDLE  | after reset, waiting for start, CPU held
// LOAD  | accepting bundles, one IMEM write per legal bundle
// DONE  | program loaded, CPU released
// ERR   | illegal format or overflow, CPU held, err_code valid
module inst_encoder_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 64
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  fmt,
   input  logic [5:0]  op,
   input  logic [5:0]  func,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   input  logic        last,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic [6:0]  count,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   localparam logic [6:0] DEPTH_C = 7'(DEPTH);

   state_t      state;
   logic        we_q;
   logic        hs;
   logic [31:0] word;
   logic [31:0] next_addr;
   logic [6:0]  count_inc;

   assign hs        = in_valid & in_ready;
   assign next_addr = BASE_ADDR + {23'b0, count, 2'b00};
   assign count_inc = count + 7'd1;

   always_comb begin
      word = '0;
      case (fmt)
         2'b00:   word = {op, func, 5'b0, rd, rs, rt};
         2'b01:   word = {op, imm, rs, rt};
         2'b10:   word = {op, target};
         default: word = '0;
      endcase
   end

   // clr kills a write strobe already on its way out, so a load aborted right after
   // a handshake leaves that word unwritten.
   assign im_we = we_q & ~clr;

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         we_q     <= 1'b0;
         im_addr  <= BASE_ADDR;
         im_wdata <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         count    <= '0;
         err_code <= 2'b00;
      end else begin
         we_q <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state    <= LOAD;
                  in_ready <= 1'b1;
                  im_addr  <= BASE_ADDR;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  count    <= '0;
                  err_code <= 2'b00;
               end
            end
            LOAD: begin
               if (hs) begin
                  if (fmt == 2'b11) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     err_code <= 2'b01;
                  end else begin
                     we_q     <= 1'b1;
                     im_addr  <= next_addr;
                     im_wdata <= word;
                     count    <= count_inc;
                     if (last) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                     end else if (count_inc == DEPTH_C) begin
                        state    <= ERR;
                        in_ready <= 1'b0;
                        err_code <= 2'b10;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: encoding table, hand-written corner sequences and
// randomized programs checked against a program-level reference model.
module tb_inst_encoder_loader;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [5:0]  func;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
      logic        last;
      int          gap;
   } ent_t;

   typedef struct {
      ent_t        e;
      logic [31:0] word;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr, start, in_valid, last;
   logic [1:0]  fmt;
   logic [5:0]  op, func;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;

   logic        in_ready, im_we, cpu_hold, done;
   logic [31:0] im_addr, im_wdata;
   logic [6:0]  count;
   logic [1:0]  err_code;

   logic        rdy4, we4, hold4, done4;
   logic [31:0] addr4, wdata4;
   logic [6:0]  count4;
   logic [1:0]  err4;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] wq[$];
   logic [63:0] wq4[$];
   ent_t        prog[$];

   always #5 clk = ~clk;

   inst_encoder_loader dut (
      .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .target(target), .last(last), .im_we(im_we), .im_addr(im_addr),
      .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .count(count),
      .err_code(err_code)
   );

   inst_encoder_loader #(.DEPTH(4)) dut4 (
      .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_ready(rdy4),
      .fmt(fmt), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .target(target), .last(last), .im_we(we4), .im_addr(addr4),
      .im_wdata(wdata4), .cpu_hold(hold4), .done(done4), .count(count4),
      .err_code(err4)
   );

   always @(negedge clk) begin
      if (im_we) wq.push_back({im_addr, im_wdata});
      if (we4)   wq4.push_back({addr4, wdata4});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input ent_t e);
      int unsigned w;
      case (e.fmt)
         2'b00:   w = e.op * 2**26 + e.func * 2**20 + e.rd * 2**10 + e.rs * 32 + e.rt;
         2'b01:   w = e.op * 2**26 + e.imm * 2**10 + e.rs * 32 + e.rt;
         default: w = e.op * 2**26 + e.target;
      endcase
      return w;
   endfunction

   task automatic do_reset();
      clr = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
      fmt = '0; op = '0; func = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
      repeat (2) begin @(posedge clk); #1; end
      clr = 1'b0;
   endtask

   task automatic do_start();
      wq.delete();
      wq4.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input ent_t e);
      bit ok = 1'b0;
      in_valid = 1'b0;
      repeat (e.gap) begin @(posedge clk); #1; end
      fmt = e.fmt; op = e.op; func = e.func; rs = e.rs; rt = e.rt; rd = e.rd;
      imm = e.imm; target = e.target; last = e.last;
      in_valid = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL handshake: in_ready never seen within 20 cycles");
      end
   endtask

   task automatic check_reset_values(input string tag);
      @(negedge clk);
      chk({tag, " im_we"}, 32'(im_we), 32'd0);
      chk({tag, " im_addr"}, im_addr, 32'h0);
      chk({tag, " im_wdata"}, im_wdata, 32'h0);
      chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " count"}, 32'(count), 32'd0);
      chk({tag, " err_code"}, 32'(err_code), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
   endtask

   // Program-level model: walk the bundle list, stop at illegal, last or a full IMEM.
   task automatic run_check(input string tag, input int depth, input logic [63:0] got[$],
                            input logic a_done, input logic a_hold,
                            input logic [1:0] a_err, input logic [6:0] a_cnt);
      logic [63:0] exp[$];
      int          n = 0;
      bit          stop = 1'b0;
      logic        e_done = 1'b0;
      logic [1:0]  e_err = 2'b00;
      for (int i = 0; i < prog.size() && !stop; i++) begin
         if (prog[i].fmt == 2'b11) begin
            e_err = 2'b01;
            stop = 1'b1;
         end else begin
            exp.push_back({32'(4 * n), enc(prog[i])});
            n++;
            if (prog[i].last) begin
               e_done = 1'b1;
               stop = 1'b1;
            end else if (n == depth) begin
               e_err = 2'b10;
               stop = 1'b1;
            end
         end
      end
      chk({tag, " nwrites"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         chk($sformatf("%s addr[%0d]", tag, i), got[i][63:32], exp[i][63:32]);
         chk($sformatf("%s data[%0d]", tag, i), got[i][31:0], exp[i][31:0]);
      end
      chk({tag, " done"}, 32'(a_done), 32'(e_done));
      chk({tag, " cpu_hold"}, 32'(a_hold), 32'(!e_done));
      chk({tag, " err_code"}, 32'(a_err), 32'(e_err));
      chk({tag, " count"}, 32'(a_cnt), 32'(n));
   endtask

   function automatic ent_t mk(input logic [1:0] f, input logic [5:0] o, input logic [5:0] fn,
                               input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                               input logic [15:0] im, input logic [25:0] tg,
                               input logic l, input int g);
      ent_t e;
      e.fmt = f; e.op = o; e.func = fn; e.rs = s; e.rt = t; e.rd = d;
      e.imm = im; e.target = tg; e.last = l; e.gap = g;
      return e;
   endfunction

   function automatic ent_t rnd_ent(input logic l);
      ent_t e;
      e.fmt    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      e.op     = 6'($urandom);
      e.func   = 6'($urandom);
      e.rs     = 5'($urandom);
      e.rt     = 5'($urandom);
      e.rd     = 5'($urandom);
      e.imm    = 16'($urandom);
      e.target = 26'($urandom);
      e.last   = l;
      e.gap    = $urandom_range(0, 3);
      return e;
   endfunction

   vec_t vecs[6];

   initial begin
      vecs[0] = '{mk(2'b00, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 0), 32'h0200_0C22};
      vecs[1] = '{mk(2'b01, 6'h08, 6'h00, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0, 1'b1, 0), 32'h23FF_F085};
      vecs[2] = '{mk(2'b10, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 1), 32'h0800_0010};
      vecs[3] = '{mk(2'b00, 6'h3F, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FF_FFFF, 1'b1, 0), 32'hFFF0_7FFF};
      vecs[4] = '{mk(2'b10, 6'h3F, 6'h15, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FF_FFFF, 1'b1, 2), 32'hFFFF_FFFF};
      vecs[5] = '{mk(2'b01, 6'h23, 6'h3F, 5'd0, 5'd0, 5'h1F, 16'h1234, 26'h3FF_FFFF, 1'b1, 0), 32'h8C48_D000};

      do_reset();
      check_reset_values("reset");

      // single-word programs: check the write cycle directly
      foreach (vecs[i]) begin
         do_start();
         send(vecs[i].e);
         @(negedge clk);
         chk($sformatf("vec%0d im_we", i), 32'(im_we), 32'd1);
         chk($sformatf("vec%0d im_addr", i), im_addr, 32'h0);
         chk($sformatf("vec%0d im_wdata", i), im_wdata, vecs[i].word);
         chk($sformatf("vec%0d done", i), 32'(done), 32'd1);
         chk($sformatf("vec%0d cpu_hold", i), 32'(cpu_hold), 32'd0);
         chk($sformatf("vec%0d count", i), 32'(count), 32'd1);
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd0);
         @(negedge clk);
         chk($sformatf("vec%0d pulse", i), 32'(im_we), 32'd0);
         @(posedge clk); #1;
      end

      // backpressure with gaps 0/2/5
      prog.delete();
      prog.push_back(mk(2'b00, 6'h00, 6'h21, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0, 0));
      prog.push_back(mk(2'b01, 6'h0D, 6'h00, 5'd2, 5'd3, 5'd0, 16'hA5A5, 26'h0, 1'b0, 2));
      prog.push_back(mk(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123_4567, 1'b1, 5));
      do_start();
      foreach (prog[i]) send(prog[i]);
      repeat (3) @(negedge clk);
      run_check("backpressure", 64, wq, done, cpu_hold, err_code, count);
      @(posedge clk); #1;

      // overflow on the DEPTH=4 instance
      prog.delete();
      for (int i = 0; i < 4; i++)
         prog.push_back(mk(2'b01, 6'(i + 1), 6'h0, 5'(i), 5'(i + 2), 5'd0, 16'(i * 3), 26'h0, 1'b0, 0));
      do_start();
      foreach (prog[i]) send(prog[i]);
      repeat (3) @(negedge clk);
      run_check("overflow4", 4, wq4, done4, hold4, err4, count4);
      chk("overflow4 in_ready", 32'(rdy4), 32'd0);
      run_check("overflow64", 64, wq, done, cpu_hold, err_code, count);
      @(posedge clk); #1;

      // illegal second bundle, then reload from BASE_ADDR
      do_reset();
      prog.delete();
      prog.push_back(mk(2'b10, 6'h02, 6'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h55, 1'b0, 0));
      prog.push_back(mk(2'b11, 6'h3F, 6'h3F, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 1));
      do_start();
      foreach (prog[i]) send(prog[i]);
      repeat (3) @(negedge clk);
      run_check("illegal", 64, wq, done, cpu_hold, err_code, count);
      chk("illegal in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      prog.delete();
      prog.push_back(mk(2'b00, 6'h00, 6'h22, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b1, 0));
      do_start();
      @(negedge clk);
      chk("reload err_code", 32'(err_code), 32'd0);
      @(posedge clk); #1;
      send(prog[0]);
      repeat (3) @(negedge clk);
      run_check("reload", 64, wq, done, cpu_hold, err_code, count);
      @(posedge clk); #1;

      // clr on the cycle after the second handshake
      prog.delete();
      do_start();
      send(mk(2'b10, 6'h01, 6'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h77, 1'b0, 0));
      send(mk(2'b10, 6'h01, 6'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h78, 1'b0, 0));
      clr = 1'b1;
      @(negedge clk);
      chk("clr strobe", 32'(im_we), 32'd0);
      @(posedge clk); #1;
      clr = 1'b0;
      check_reset_values("clr");
      chk("clr nwrites", 32'(wq.size()), 32'd1);
      @(posedge clk); #1;

      // randomized programs against both instances
      for (int p = 0; p < 25; p++) begin
         int len = $urandom_range(1, 8);
         prog.delete();
         for (int i = 0; i < len; i++) begin
            prog.push_back(rnd_ent(i == len - 1));
            if (prog[i].fmt == 2'b11) break;
         end
         do_start();
         foreach (prog[i]) send(prog[i]);
         repeat (3) @(negedge clk);
         run_check($sformatf("rnd%0d", p), 64, wq, done, cpu_hold, err_code, count);
         run_check($sformatf("rnd%0d/d4", p), 4, wq4, done4, hold4, err4, count4);
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
